data_struct_arbiter: RTL and testbench

Round-robin arbiter and output sequencer for the shared 8-bit packed data struct that drives the top-level `o_a` bus. Up to `N_REQ` requesters each present a byte. The block grants one requester per transfer and captures its byte into the struct's `data` field. It then holds the byte on `o_a` under a valid/ready handshake until the downstream consumer takes it. It replaces the static all-ones tie-off of the struct with a sequenced, shared source.

---
 rtl/data_struct_arbiter.sv | 92 +++++++++
 tb/tb_data_struct_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_struct_arbiter.sv
// Round-robin arbiter feeding the shared packed struct data field on o_a.
// One requester is granted per open slot and its byte is held under valid/ready.
module data_struct_arbiter #(
  parameter int           N_REQ   = 4,
  parameter int           DW      = 8,
  parameter logic [DW-1:0] RST_VAL = 8'hFF,
  localparam int          OW      = $clog2(N_REQ)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [DW-1:0]     o_a,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OW-1:0]     o_owner,
  output logic [15:0]       o_xfer_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic            slot_open;
  logic            grant;
  logic            xfer;
  logic [DW-1:0]   a_p1;
  logic [OW-1:0]   owner_p1;
  logic [15:0]     cnt;

  assign slot_open = (state == EMPTY) || i_ready;
  assign xfer      = (state == FULL) && i_ready;
  // A grant in the reset cycle would be discarded anyway, so it is never shown.
  assign grant     = slot_open && pick_vld && !i_rst;

  // Stage p0: search from ptr+1 upward, wrapping, for the first active request.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!pick_vld && i_req[(int'(ptr) + i) % N_REQ]) begin
        pick_vld = 1'b1;
        pick     = OW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (grant) o_gnt[pick] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL:  if (i_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Stage p1: captured winner byte, owner and rotating priority pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_p1     <= RST_VAL;
      owner_p1 <= '0;
      ptr      <= OW'(N_REQ - 1);
      cnt      <= '0;
    end else begin
      if (grant) begin
        a_p1     <= i_data[pick*DW +: DW];
        owner_p1 <= pick;
        ptr      <= pick;
      end
      if (xfer) cnt <= cnt + 16'd1;
    end
  end

  assign o_a        = a_p1;
  assign o_owner    = owner_p1;
  assign o_valid    = (state == FULL);
  assign o_xfer_cnt = cnt;

endmodule

// File: tb/tb_data_struct_arbiter.sv
// Scoreboard bench for data_struct_arbiter: directed scenarios, random traffic
// and a full 16-bit counter wrap, all against a transaction-level model.
module tb_data_struct_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            i_clk;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    o_gnt;
  logic [DW-1:0]   o_a;
  logic            o_valid;
  logic            i_ready;
  logic [1:0]      o_owner;
  logic [15:0]     o_xfer_cnt;

  data_struct_arbiter #(.N_REQ(N), .DW(DW), .RST_VAL(8'hFF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data),
    .o_gnt(o_gnt), .o_a(o_a), .o_valid(o_valid), .i_ready(i_ready),
    .o_owner(o_owner), .o_xfer_cnt(o_xfer_cnt)
  );

  typedef struct {int k; logic [7:0] d;} exp_t;
  exp_t q[$];

  int nchk = 0;
  int nfail = 0;

  // Model state: which requester last won, whether a byte is pending, transfer count.
  int          m_last;
  bit          m_full;
  logic [15:0] m_cnt;
  int          last_gnt;

  logic [N-1:0] req_v;
  logic [7:0]   dat_v [N];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotating priority: first requester after the last winner, going upward.
  function automatic int model_pick(input logic [N-1:0] req, input int last);
    for (int off = 1; off <= N; off++)
      if (req[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  task automatic cycle(input logic rst_in, input logic rdy);
    int k;
    logic [N-1:0] eg;
    @(negedge i_clk);
    i_rst   = rst_in;
    i_ready = rdy;
    i_req   = req_v;
    for (int j = 0; j < N; j++) i_data[j*DW +: DW] = dat_v[j];
    #1;
    k  = -1;
    eg = '0;
    if (!rst_in && (!m_full || rdy)) k = model_pick(req_v, m_last);
    if (k >= 0) eg[k] = 1'b1;
    chk("gnt", int'(o_gnt), int'(eg));
    chk("valid", int'(o_valid), int'(m_full));
    chk("xfer_cnt", int'(o_xfer_cnt), int'(m_cnt));
    if (rst_in) begin
      m_full = 1'b0;
      m_last = N - 1;
      m_cnt  = '0;
      q.delete();
    end else begin
      if (m_full && rdy) begin
        m_cnt  = m_cnt + 16'd1;
        m_full = 1'b0;
      end
      if (k >= 0) begin
        q.push_back('{k: k, d: dat_v[k]});
        m_last = k;
        m_full = 1'b1;
      end
    end
    last_gnt = k;
  endtask

  task automatic do_reset();
    req_v = '0;
    cycle(1'b1, 1'b0);
  endtask

  // Monitor: every accepted byte must match the oldest expected transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_rst && o_valid && i_ready) begin
        if (q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL sb_empty: got byte %0h with no expected transfer", o_a);
        end else begin
          e = q.pop_front();
          chk("sb_data", int'(o_a), int'(e.d));
          chk("sb_owner", int'(o_owner), e.k);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] seen [5];
    i_rst = 1'b1; i_ready = 1'b0; i_req = '0; i_data = '0;
    req_v = '0;
    for (int j = 0; j < N; j++) dat_v[j] = '0;
    m_last = N - 1; m_full = 1'b0; m_cnt = '0; last_gnt = -1;

    // Reset held two cycles, then idle.
    do_reset();
    do_reset();
    cycle(1'b0, 1'b0);
    chk("rst_a", int'(o_a), 8'hFF);
    chk("rst_owner", int'(o_owner), 0);
    chk("rst_gnt", int'(o_gnt), 0);

    // Single request from requester 2.
    req_v = 4'b0100; dat_v[2] = 8'h5A;
    cycle(1'b0, 1'b1);
    chk("single_gnt", int'(o_gnt), 4'b0100);
    req_v = '0;
    cycle(1'b0, 1'b1);
    chk("single_a", int'(o_a), 8'h5A);
    chk("single_owner", int'(o_owner), 2);
    cycle(1'b0, 1'b1);
    chk("single_cnt", int'(o_xfer_cnt), 1);

    // Round-robin order with everyone requesting.
    do_reset();
    req_v = 4'b1111;
    for (int j = 0; j < N; j++) dat_v[j] = 8'h10 + 8'(j);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b1);
      seen[c] = o_gnt;
    end
    chk("rr_0", int'(seen[0]), 4'b0001);
    chk("rr_1", int'(seen[1]), 4'b0010);
    chk("rr_2", int'(seen[2]), 4'b0100);
    chk("rr_3", int'(seen[3]), 4'b1000);
    chk("rr_4", int'(seen[4]), 4'b0001);
    req_v = '0;
    cycle(1'b0, 1'b1);
    chk("rr_a", int'(o_a), 8'h10);

    // Backpressure while requester 3 waits.
    do_reset();
    req_v = 4'b0010; dat_v[1] = 8'hA5;
    cycle(1'b0, 1'b1);
    req_v = 4'b1000; dat_v[3] = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b0);
      chk("bp_hold_a", int'(o_a), 8'hA5);
      chk("bp_hold_gnt", int'(o_gnt), 0);
    end
    cycle(1'b0, 1'b1);
    chk("bp_release_gnt", int'(o_gnt), 4'b1000);
    req_v = '0;
    cycle(1'b0, 1'b0);
    chk("bp_new_a", int'(o_a), 8'h3C);

    // Reset while a byte is pending under backpressure.
    do_reset();
    req_v = 4'b0100; dat_v[2] = 8'h77;
    cycle(1'b0, 1'b0);
    req_v = '0;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_a", int'(o_a), 8'hFF);
    chk("mid_rst_cnt", int'(o_xfer_cnt), 0);
    req_v = 4'b1001; dat_v[0] = 8'h01; dat_v[3] = 8'h03;
    cycle(1'b0, 1'b1);
    chk("mid_rst_gnt", int'(o_gnt), 4'b0001);

    // Random traffic obeying the requester hold rules.
    req_v = 4'b1000;
    for (int c = 0; c < 2000; c++) begin
      for (int j = 0; j < N; j++) begin
        if (last_gnt == j) begin
          req_v[j] = 1'($urandom_range(0, 1));
          dat_v[j] = 8'($urandom);
        end else if (!req_v[j]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_v[j] = 1'b1;
            dat_v[j] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[j] = 1'b0;
        end
      end
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
    end

    // Counter wrap: 65536 back-to-back transfers return the count to zero.
    do_reset();
    req_v = 4'b1111;
    for (int j = 0; j < N; j++) dat_v[j] = 8'hC0 + 8'(j);
    for (int c = 0; c < 65538; c++) cycle(1'b0, 1'b1);
    chk("wrap_cnt", int'(o_xfer_cnt), 0);
    chk("wrap_valid", int'(o_valid), 1);
    req_v = '0;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("wrap_drain", int'(o_xfer_cnt), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
